// File: rtl/alloc_free_bitmap64_if.sv
// Allocator handshake bundle: staged-index grant channel plus the index-return channel.
// slave = allocator side, master = rename/alloc consumer side.
interface alloc_free_bitmap64_if;
  logic       out_vld;
  logic [5:0] out_idx;
  logic       out_rdy;
  logic       free_en;
  logic [5:0] free_idx;

  modport slave (
    output out_vld,
    output out_idx,
    input  out_rdy,
    input  free_en,
    input  free_idx
  );

  modport master (
    input  out_vld,
    input  out_idx,
    output out_rdy,
    output free_en,
    output free_idx
  );
endinterface

// File: rtl/alloc_free_bitmap64.sv
// 64-entry free-list allocator: free bitmap, highest-free-bit finder and a one-deep staged index.
// Optional macro ALLOC_DBLFREE_CHK_EN drops double frees and raises a sticky err_dblfree.
module alloc_free_bitmap64 #(
  parameter logic [63:0] INIT_FREE = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic [6:0]  LOW_WM    = 7'd4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  alloc_free_bitmap64_if.slave         bus,
  output logic [6:0]                   free_cnt,
  output logic                         free_low,
  output logic                         err_dblfree
);

  localparam logic [6:0] INIT_CNT = 7'($countones(INIT_FREE));
  localparam logic       INIT_LOW = (INIT_CNT <= LOW_WM);

  logic [63:0] bitmap_reg, bitmap_next;
  logic        out_vld_reg, out_vld_next;
  logic [5:0]  out_idx_reg, out_idx_next;
  logic [6:0]  free_cnt_reg, free_cnt_next;
  logic        free_low_reg;

  logic [5:0]  pick;
  logic        hasany;
  logic        load;
  logic [63:0] bitmap_after_load;
  logic        free_ok;
  logic        free_inc;
  logic [7:0]  cnt_sum;

  // Highest set bit wins: later iterations overwrite earlier ones.
  always_comb begin
    pick   = 6'd0;
    hasany = |bitmap_reg;
    for (int i = 0; i < 64; i++) begin
      if (bitmap_reg[i]) pick = 6'(i);
    end
  end

`ifdef ALLOC_DBLFREE_CHK_EN
  logic err_reg, err_next;
  logic dbl;
`endif

  always_comb begin
    load              = hasany & (~out_vld_reg | bus.out_rdy);
    bitmap_after_load = bitmap_reg & ~(load ? (64'd1 << pick) : 64'd0);
`ifdef ALLOC_DBLFREE_CHK_EN
    dbl      = bus.free_en & (bitmap_reg[bus.free_idx]
             | (out_vld_reg & (bus.free_idx == out_idx_reg) & ~bus.out_rdy)
             | (load & (bus.free_idx == pick)));
    free_ok  = bus.free_en & ~dbl;
    err_next = err_reg | dbl;
`else
    free_ok  = bus.free_en;
`endif
    // A free onto a bit that is still set after the load is idempotent; one that
    // collides with the pick re-sets the bit, which keeps the count net zero.
    free_inc    = free_ok & ~bitmap_after_load[bus.free_idx];
    bitmap_next = bitmap_after_load | (free_ok ? (64'd1 << bus.free_idx) : 64'd0);

    cnt_sum       = {1'b0, free_cnt_reg} - {7'd0, load} + {7'd0, free_inc};
    free_cnt_next = (cnt_sum > 8'd64) ? 7'd64 : cnt_sum[6:0];

    out_vld_next = out_vld_reg;
    out_idx_next = out_idx_reg;
    if (load) begin
      out_vld_next = 1'b1;
      out_idx_next = pick;
    end else if (out_vld_reg & bus.out_rdy) begin
      out_vld_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst | flush) begin
      bitmap_reg   <= INIT_FREE;
      out_vld_reg  <= 1'b0;
      out_idx_reg  <= 6'd0;
      free_cnt_reg <= INIT_CNT;
      free_low_reg <= INIT_LOW;
    end else begin
      bitmap_reg   <= bitmap_next;
      out_vld_reg  <= out_vld_next;
      out_idx_reg  <= out_idx_next;
      free_cnt_reg <= free_cnt_next;
      free_low_reg <= (free_cnt_next <= LOW_WM);
    end
  end

`ifdef ALLOC_DBLFREE_CHK_EN
  always_ff @(posedge clk) begin
    if (rst | flush) err_reg <= 1'b0;
    else             err_reg <= err_next;
  end
  assign err_dblfree = err_reg;
`else
  assign err_dblfree = 1'b0;
`endif

  assign bus.out_vld = out_vld_reg;
  assign bus.out_idx = out_idx_reg;
  assign free_cnt    = free_cnt_reg;
  assign free_low    = free_low_reg;

endmodule
